// File: rtl/fp_vec_mul_seq.sv
// Sequential element-wise FP vector multiplier: reads operand pairs, drives an external
// combinational multiplier, writes results back and counts infinite products.
module fp_vec_mul_seq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          mode,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_a,
    input  logic [31:0]   rd_b,
    output logic [31:0]   mul_a,
    output logic [31:0]   mul_b,
    output logic          mul_sel,
    input  logic [31:0]   mul_product,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [AW:0]   inf_cnt
);

    typedef enum logic [2:0] {IDLE, READ, MUL, WRITE, DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    state_t      state, state_nxt;
    logic [AW:0] idx;
    logic [AW:0] len_q;
    logic        mode_q;
    logic        last_elem;

    function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
        return (l > DEPTH_L) ? DEPTH_L : l;
    endfunction

    // Binary16 operands and results live in the low half with the upper half zeroed.
    function automatic logic [31:0] fmt_word(input logic half, input logic [31:0] w);
        return half ? {16'b0, w[15:0]} : w;
    endfunction

    function automatic logic is_inf(input logic half, input logic [31:0] p);
        return half ? (&p[14:10]) : (&p[30:23]);
    endfunction

    assign last_elem = ((idx + ONE) == len_q);
    assign mul_sel   = mode_q;

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        rd_en     = (state == READ);
        wr_en     = (state == WRITE);
        rd_addr   = '0;
        wr_addr   = '0;
        wr_data   = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len != '0) ? READ : DONE;
            end
            READ: begin
                rd_addr   = idx[AW-1:0];
                state_nxt = MUL;
            end
            MUL: state_nxt = WRITE;
            WRITE: begin
                wr_addr   = idx[AW-1:0];
                wr_data   = fmt_word(mode_q, mul_product);
                state_nxt = last_elem ? DONE : READ;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
            inf_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        inf_cnt <= '0;
                        mode_q  <= mode;
                        len_q   <= clamp_len(len);
                    end
                end
                // rd_a/rd_b are valid here, one cycle after the READ request.
                MUL: begin
                    mul_a <= fmt_word(mode_q, rd_a);
                    mul_b <= fmt_word(mode_q, rd_b);
                end
                WRITE: begin
                    idx <= idx + ONE;
                    if (is_inf(mode_q, mul_product)) inf_cnt <= inf_cnt + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_vec_mul_seq.sv
// Directed, table-driven bench for fp_vec_mul_seq with an operand memory model and a
// lookup-based stand-in for the external FP multiplier.
module tb_fp_vec_mul_seq;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst, start, mode;
    logic [AW:0]   len;
    logic          busy, done, rd_en, wr_en, mul_sel;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   rd_a, rd_b, mul_a, mul_b, mul_product, wr_data;
    logic [AW:0]   inf_cnt;

    fp_vec_mul_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_a(rd_a), .rd_b(rd_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_sel(mul_sel), .mul_product(mul_product), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .inf_cnt(inf_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
    end

    // Known products only; anything unexpected yields a poison value.
    function automatic logic [31:0] fmul(input logic sel, input logic [31:0] a, input logic [31:0] b);
        if (!sel) begin
            if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40000000;
            if (a == 32'h40400000 && b == 32'h40400000) return 32'h41100000;
            if (a == 32'h7F000000 && b == 32'h7F000000) return 32'h7F800000;
        end else begin
            if (a == 32'h00003C00 && b == 32'h00004000) return 32'hA5A54000;
            if (a == 32'h00007800 && b == 32'h00007800) return 32'h5A5A7C00;
        end
        return 32'hDEADBEEF;
    endfunction

    always_comb mul_product = fmul(mul_sel, mul_a, mul_b);

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [31:0] log_mula [$];
    logic        log_sel  [$];
    int          rd_cnt, done_cnt, overlap_cnt;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(32'(wr_addr));
            log_data.push_back(wr_data);
            log_mula.push_back(mul_a);
            log_sel.push_back(mul_sel);
        end
        if (rd_en) rd_cnt++;
        if (done) done_cnt++;
        if (rd_en && wr_en) overlap_cnt++;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          mode;
        logic [2:0]    len;
        logic [127:0]  a;        // {e3, e2, e1, e0}
        logic [127:0]  b;
        int            exp_n;
        logic [127:0]  exp_d;    // {d3, d2, d1, d0}
        logic [31:0]   exp_mula0;
        int            exp_inf;
        int            exp_cyc;
        int            glitch_at;
    } vec_t;

    vec_t vecs [6];

    task automatic clear_logs();
        log_addr.delete(); log_data.delete(); log_mula.delete(); log_sel.delete();
        rd_cnt = 0; done_cnt = 0; overlap_cnt = 0;
    endtask

    task automatic run_op(input int vi);
        vec_t v;
        int   n;
        bit   got;
        v = vecs[vi];
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = v.a[32*i +: 32];
            mem_b[i] = v.b[32*i +: 32];
        end
        @(negedge clk);
        clear_logs();
        mode  = v.mode;
        len   = v.len;
        start = 1'b1;
        n     = 0;
        got   = 1'b0;
        while (n < 100 && !got) begin
            @(posedge clk);
            n++;
            #1;
            // Scramble mode/len while busy; a start glitch must also be ignored.
            start = (n == v.glitch_at);
            mode  = 1'($urandom);
            len   = 3'($urandom);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) check($sformatf("v%0d done_timeout", vi), 32'd0, 32'd1);
        else begin
            check($sformatf("v%0d done_edge", vi), 32'(n - 1), 32'(v.exp_cyc));
            check($sformatf("v%0d inf_at_done", vi), 32'(inf_cnt), 32'(v.exp_inf));
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check($sformatf("v%0d n_writes", vi), 32'(log_data.size()), 32'(v.exp_n));
        check($sformatf("v%0d n_reads", vi), 32'(rd_cnt), 32'(v.exp_n));
        check($sformatf("v%0d done_pulses", vi), 32'(done_cnt), 32'd1);
        check($sformatf("v%0d rd_wr_overlap", vi), 32'(overlap_cnt), 32'd0);
        check($sformatf("v%0d inf_hold", vi), 32'(inf_cnt), 32'(v.exp_inf));
        check($sformatf("v%0d idle_busy", vi), 32'(busy), 32'd0);
        for (int i = 0; i < log_data.size() && i < v.exp_n; i++) begin
            check($sformatf("v%0d wr_addr[%0d]", vi, i), log_addr[i], 32'(i));
            check($sformatf("v%0d wr_data[%0d]", vi, i), log_data[i], v.exp_d[32*i +: 32]);
            check($sformatf("v%0d mul_sel[%0d]", vi, i), 32'(log_sel[i]), 32'(v.mode));
        end
        if (v.exp_n > 0 && log_mula.size() > 0)
            check($sformatf("v%0d mul_a[0]", vi), log_mula[0], v.exp_mula0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; len = '0;
        clear_logs();

        vecs[0] = '{mode: 1'b0, len: 3'd2,
                    a: {32'h0, 32'h0, 32'h40400000, 32'h3F800000},
                    b: {32'h0, 32'h0, 32'h40400000, 32'h40000000},
                    exp_n: 2, exp_d: {32'h0, 32'h0, 32'h41100000, 32'h40000000},
                    exp_mula0: 32'h3F800000, exp_inf: 0, exp_cyc: 6, glitch_at: 0};
        vecs[1] = '{mode: 1'b1, len: 3'd1,
                    a: {32'h0, 32'h0, 32'h0, 32'hABCD3C00},
                    b: {32'h0, 32'h0, 32'h0, 32'h12344000},
                    exp_n: 1, exp_d: {32'h0, 32'h0, 32'h0, 32'h00004000},
                    exp_mula0: 32'h00003C00, exp_inf: 0, exp_cyc: 3, glitch_at: 0};
        vecs[2] = '{mode: 1'b0, len: 3'd4,
                    a: {32'h40400000, 32'h7F000000, 32'h3F800000, 32'h7F000000},
                    b: {32'h40400000, 32'h7F000000, 32'h40000000, 32'h7F000000},
                    exp_n: 4, exp_d: {32'h41100000, 32'h7F800000, 32'h40000000, 32'h7F800000},
                    exp_mula0: 32'h7F000000, exp_inf: 2, exp_cyc: 12, glitch_at: 4};
        vecs[3] = '{mode: 1'b0, len: 3'd0,
                    a: 128'h0, b: 128'h0, exp_n: 0, exp_d: 128'h0,
                    exp_mula0: 32'h0, exp_inf: 0, exp_cyc: 0, glitch_at: 0};
        vecs[4] = '{mode: 1'b0, len: 3'd7,
                    a: {32'h40400000, 32'h7F000000, 32'h3F800000, 32'h7F000000},
                    b: {32'h40400000, 32'h7F000000, 32'h40000000, 32'h7F000000},
                    exp_n: 4, exp_d: {32'h41100000, 32'h7F800000, 32'h40000000, 32'h7F800000},
                    exp_mula0: 32'h7F000000, exp_inf: 2, exp_cyc: 12, glitch_at: 7};
        vecs[5] = '{mode: 1'b1, len: 3'd1,
                    a: {32'h0, 32'h0, 32'h0, 32'hFFFF7800},
                    b: {32'h0, 32'h0, 32'h0, 32'h00017800},
                    exp_n: 1, exp_d: {32'h0, 32'h0, 32'h0, 32'h00007C00},
                    exp_mula0: 32'h00007800, exp_inf: 1, exp_cyc: 3, glitch_at: 2};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; len = 3'd2;      // start must lose to rst
        @(posedge clk); #1;
        start = 1'b0;
        check("rst busy",    32'(busy),    32'd0);
        check("rst done",    32'(done),    32'd0);
        check("rst rd_en",   32'(rd_en),   32'd0);
        check("rst wr_en",   32'(wr_en),   32'd0);
        check("rst rd_addr", 32'(rd_addr), 32'd0);
        check("rst wr_addr", 32'(wr_addr), 32'd0);
        check("rst wr_data", wr_data,      32'd0);
        check("rst mul_a",   mul_a,        32'd0);
        check("rst mul_b",   mul_b,        32'd0);
        check("rst inf_cnt", 32'(inf_cnt), 32'd0);
        check("rst mul_sel", 32'(mul_sel), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int vi = 0; vi < 6; vi++) run_op(vi);

        // Reset during MUL of element 1 aborts the operation
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = vecs[0].a[32*i +: 32];
            mem_b[i] = vecs[0].b[32*i +: 32];
        end
        @(negedge clk);
        clear_logs();
        mode = 1'b0; len = 3'd2; start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        check("abort in_mul busy",  32'(busy),  32'd1);
        check("abort in_mul rd_en", 32'(rd_en), 32'd0);
        check("abort in_mul wr_en", 32'(wr_en), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy_after_rst", 32'(busy),    32'd0);
        check("abort inf_cnt",        32'(inf_cnt), 32'd0);
        check("abort mul_a",          mul_a,        32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort n_writes",    32'(log_data.size()), 32'd1);
        check("abort done_pulses", 32'(done_cnt),        32'd0);
        check("abort idle_busy",   32'(busy),            32'd0);

        // A fresh operation still works after the abort
        run_op(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
